dmem_ctrl: RTL and testbench



---
 rtl/dmem_ctrl.sv | 173 +++++++++++++++++
 tb/tb_dmem_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Data memory controller: b/h/w stores, extended loads, fixed read latency.
// Define DMEM_TRACE_EN to print one trace line per committed store.
module dmem_ctrl #(
  parameter int ADDR_SIZE   = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1,
  parameter logic [ADDR_SIZE-1:0] BASE_ADDR = '0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 reqValid,
  output logic                 reqReady,
  input  logic                 reqWrite,
  input  logic [2:0]           reqFunct3,
  input  logic [ADDR_SIZE-1:0] reqAddr,
  input  logic [31:0]          reqWdata,
  input  logic [ADDR_SIZE-1:0] pc,
  output logic                 respValid,
  input  logic                 respReady,
  output logic [31:0]          respRdata,
  output logic                 respErr
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam longint LIMIT = longint'(DEPTH_WORDS) * 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, state_nxt;
  logic [2:0]  cnt;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [ADDR_SIZE-1:0] off;
  logic [IW-1:0]        idx;
  logic [1:0]           lane;
  logic                 accept;
  logic                 is_b, is_h, is_w, uns, fn_err;
  logic                 align_err, range_err, err_c;
  logic                 wr_en;
  logic [3:0]           be;
  logic [31:0]          wlane, rd_word, merged, shifted, ext, load_data;

  assign off  = reqAddr - BASE_ADDR;
  assign idx  = off[IW+1:2];
  assign lane = off[1:0];
  assign accept = reqValid && reqReady;

  always_comb begin
    is_b   = 1'b0;
    is_h   = 1'b0;
    is_w   = 1'b0;
    uns    = 1'b0;
    fn_err = 1'b0;
    case (reqFunct3)
      3'b000: is_b = 1'b1;
      3'b001: is_h = 1'b1;
      3'b010: is_w = 1'b1;
      3'b100: begin
        is_b   = 1'b1;
        uns    = 1'b1;
        fn_err = reqWrite;
      end
      3'b101: begin
        is_h   = 1'b1;
        uns    = 1'b1;
        fn_err = reqWrite;
      end
      default: fn_err = 1'b1;
    endcase
  end

  assign align_err = (is_h && off[0]) || (is_w && (off[1:0] != 2'b00));
  assign range_err = (64'(off) >= 64'(LIMIT));
  assign err_c     = range_err || fn_err || align_err;
  // rstn gate keeps the RAM untouched while reset is held
  assign wr_en     = accept && reqWrite && !err_c && rstn;

  always_comb begin
    be    = 4'b0000;
    wlane = reqWdata;
    unique case (1'b1)
      is_b: begin
        be    = 4'b0001 << lane;
        wlane = {4{reqWdata[7:0]}};
      end
      is_h: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wlane = {2{reqWdata[15:0]}};
      end
      is_w: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign rd_word = mem[idx];

  always_comb begin
    merged = rd_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wlane[8*i +: 8];
    end
  end

  assign shifted = rd_word >> {lane, 3'b000};

  always_comb begin
    ext = rd_word;
    unique case (1'b1)
      is_b: ext = uns ? {24'b0, shifted[7:0]}
                      : {{24{shifted[7]}}, shifted[7:0]};
      is_h: ext = uns ? {16'b0, shifted[15:0]}
                      : {{16{shifted[15]}}, shifted[15:0]};
      default: ext = rd_word;
    endcase
  end

  assign load_data = (err_c || reqWrite) ? 32'b0 : ext;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
`ifdef DMEM_TRACE_EN
      $display("pc = %h: dataaddr = %h, memdata = %h",
               pc, {reqAddr[ADDR_SIZE-1:2], 2'b00}, merged);
`endif
    end
  end

  logic unused_pc;
  assign unused_pc = ^pc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (cnt == 3'd1) state_nxt = RESP;
      RESP: if (respReady) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    reqReady  = (state == IDLE);
    respValid = (state == RESP);
    respRdata = rdata_q;
    respErr   = err_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt     <= 3'd0;
      rdata_q <= 32'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      cnt     <= 3'(LATENCY - 1);
      rdata_q <= load_data;
      err_q   <= err_c;
    end else if (state == WAIT) begin
      cnt <= cnt - 3'd1;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: driver pushes model results,
// a negedge monitor pops and compares each response.
module tb_dmem_ctrl;

  localparam int LAT   = 4;
  localparam int DEPTH = 1024;
  localparam logic [31:0] BASE = 32'h0;

  logic        clk = 1'b0;
  logic        rstn;
  logic        reqValid, reqReady, reqWrite;
  logic [2:0]  reqFunct3;
  logic [31:0] reqAddr, reqWdata, pc;
  logic        respValid, respReady, respErr;
  logic [31:0] respRdata;

  dmem_ctrl #(
    .ADDR_SIZE(32), .DEPTH_WORDS(DEPTH),
    .LATENCY(LAT), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rstn(rstn),
    .reqValid(reqValid), .reqReady(reqReady),
    .reqWrite(reqWrite), .reqFunct3(reqFunct3),
    .reqAddr(reqAddr), .reqWdata(reqWdata), .pc(pc),
    .respValid(respValid), .respReady(respReady),
    .respRdata(respRdata), .respErr(respErr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   in_resp = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  bit [7:0] mm [int unsigned];

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
  endtask

  // byte-addressed memory model; sizes and signedness from funct3
  function automatic void model(input bit wr, input bit [2:0] f3,
                                input bit [31:0] addr, input bit [31:0] wd,
                                output logic [31:0] rd, output logic er);
    bit [31:0] off;
    int sz;
    bit sgn;
    longint v;
    longint one;
    one = 1;
    off = addr - BASE;
    sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    sgn = !f3[2];
    er  = (f3 == 3'd3) || (f3 >= 3'd6) || (wr && f3[2]) ||
          (off >= 32'(4 * DEPTH)) || ((off % sz) != 0);
    rd  = 32'b0;
    if (er) return;
    if (wr) begin
      for (int i = 0; i < sz; i++) mm[off + i] = wd[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < sz; i++) begin
        if (!mm.exists(off + i)) $display("note: unwritten byte read");
        v = v | (longint'(mm[off + i]) << (8 * i));
      end
      if (sgn && sz < 4 && v >= (one << (8 * sz - 1)))
        v = v - (one << (8 * sz));
      rd = v[31:0];
    end
  endfunction

  always @(negedge clk) begin
    if (respValid === 1'b1) begin
      if (!in_resp) begin
        if (q.size() == 0) begin
          chk(1'b0, "unexpected_resp", respRdata, 32'h0);
        end else begin
          cur = q.pop_front();
          chk(respRdata === cur.rdata, "rdata", respRdata, cur.rdata);
          chk(respErr === cur.err, "err", 32'(respErr), 32'(cur.err));
          chk(cyc - cur.acc + 1 == LAT, "latency",
              32'(cyc - cur.acc + 1), 32'(LAT));
        end
        in_resp = 1;
      end else begin
        chk(respRdata === cur.rdata, "rdata_hold", respRdata, cur.rdata);
        chk(respErr === cur.err, "err_hold", 32'(respErr), 32'(cur.err));
      end
      chk(reqReady === 1'b0, "ready_low_in_resp", 32'(reqReady), 32'h0);
      if (respReady === 1'b1) in_resp = 0;
    end else begin
      in_resp = 0;
    end
  end

  task automatic req(input bit wr, input bit [2:0] f3,
                     input bit [31:0] addr, input bit [31:0] wd,
                     input int stall);
    exp_t e;
    int n;
    n = 0;
    while (reqReady !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk(reqReady === 1'b1, "ready_wait", 32'(reqReady), 32'h1);
    reqValid  = 1'b1;
    reqWrite  = wr;
    reqFunct3 = f3;
    reqAddr   = addr;
    reqWdata  = wd;
    pc        = $urandom;
    model(wr, f3, addr, wd, e.rdata, e.err);
    @(posedge clk); #1;
    reqValid = 1'b0;
    reqAddr  = $urandom;
    reqWdata = $urandom;
    e.acc = cyc;
    q.push_back(e);
    n = 0;
    while (respValid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk(respValid === 1'b1, "resp_timeout", 32'(respValid), 32'h1);
    if (respValid === 1'b1) begin
      repeat (stall) begin
        @(posedge clk); #1;
      end
      respReady = 1'b1;
      @(posedge clk); #1;
      respReady = 1'b0;
      chk(reqReady === 1'b1, "ready_after_resp", 32'(reqReady), 32'h1);
      chk(respValid === 1'b0, "valid_after_resp", 32'(respValid), 32'h0);
    end
  endtask

  initial begin
    logic [31:0] dr;
    logic de;
    int n;
    bit wr;
    bit [2:0] f3;
    bit [31:0] addr;
    bit [2:0] ld_f3 [5];
    ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    rstn = 1'b0;
    reqValid = 1'b0;
    reqWrite = 1'b0;
    reqFunct3 = 3'd0;
    reqAddr = 32'h0;
    reqWdata = 32'h0;
    pc = 32'h0;
    respReady = 1'b0;
    #3;
    chk(reqReady === 1'b1, "rst_ready", 32'(reqReady), 32'h1);
    chk(respValid === 1'b0, "rst_valid", 32'(respValid), 32'h0);
    chk(respRdata === 32'h0, "rst_rdata", respRdata, 32'h0);
    chk(respErr === 1'b0, "rst_err", 32'(respErr), 32'h0);
    #9 rstn = 1'b1;
    @(posedge clk); #1;

    req(1, 3'd2, 32'h8, 32'hDEADBEEF, 0);
    req(0, 3'd2, 32'h8, 32'h0, 0);
    req(1, 3'd0, 32'h9, 32'h55, 1);
    req(0, 3'd2, 32'h8, 32'h0, 0);
    req(0, 3'd0, 32'h9, 32'h0, 0);
    req(0, 3'd0, 32'hB, 32'h0, 2);
    req(0, 3'd4, 32'hB, 32'h0, 0);
    req(1, 3'd2, 32'h0, 32'h11223344, 0);
    req(1, 3'd1, 32'h2, 32'h8001, 0);
    req(0, 3'd1, 32'h2, 32'h0, 0);
    req(0, 3'd5, 32'h2, 32'h0, 0);
    req(1, 3'd1, 32'h3, 32'hFFFF, 0);
    req(0, 3'd2, 32'h0, 32'h0, 0);
    req(0, 3'd2, 32'h1000, 32'h0, 0);
    req(1, 3'd4, 32'h8, 32'h77, 0);
    req(0, 3'd2, 32'h8, 32'h0, 0);
    req(1, 3'd2, 32'hFFC, 32'hA5A5_1234, 0);
    req(0, 3'd2, 32'hFFC, 32'h0, 0);
    req(0, 3'd2, 32'h8, 32'h0, 10);

    // store accepted, then reset while the response is still pending
    reqValid  = 1'b1;
    reqWrite  = 1'b1;
    reqFunct3 = 3'd2;
    reqAddr   = 32'h10;
    reqWdata  = 32'hCAFEF00D;
    model(1, 3'd2, 32'h10, 32'hCAFEF00D, dr, de);
    @(posedge clk); #1;
    reqValid = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    chk(respValid === 1'b0, "midrst_valid", 32'(respValid), 32'h0);
    chk(reqReady === 1'b1, "midrst_ready", 32'(reqReady), 32'h1);
    #2 rstn = 1'b1;
    @(posedge clk); #1;
    req(0, 3'd2, 32'h10, 32'h0, 0);

    for (int i = 0; i < 16; i++) req(1, 3'd2, 32'(i * 4), $urandom, 0);

    for (int i = 0; i < 250; i++) begin
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 7) begin
        f3 = wr ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
        addr = 32'($urandom_range(0, 63));
      end else begin
        f3 = 3'($urandom_range(0, 7));
        addr = $urandom_range(0, 1) ? 32'($urandom_range(0, 63))
                                    : (32'h1000 | $urandom);
      end
      req(wr, f3, addr, $urandom, $urandom_range(0, 3));
    end

    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk(q.size() == 0, "queue_drain", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
